division_seq_led_board: RTL and testbench
=========================================

# division_seq_led_board

Board-level demo wrapper around a sequential (one bit per clock) unsigned integer divider. A debounced-by-synchronisation, active-low push-button starts one division of two build-time constant operands. The result is shown on four discrete LEDs (quotient low nibble) and one active-low 7-segment digit (remainder low nibble). It is the top level for the FPGA board; the divider core sits beneath it.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits
- DIVIDEND, 16'd1000, constant dividend
- DIVISOR, 16'd7, constant divisor

Ports:
- clk  input  1  system clock, 50 MHz (20 ns period)
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  push-button, active-low (idle 1), asynchronous to clk
- done  output  1  high once a division has completed; held until next accepted start
- out  output  7  7-segment pattern {g,f,e,d,c,b,a}, active-low (0 = segment lit)
- led1  output  1  quotient[0], active-high
- led2  output  1  quotient[1]
- led3  output  1  quotient[2]
- led4  output  1  quotient[3]

## Operation
- start passes through a 2-flop synchroniser; a 1→0 transition of the synchronised signal yields a one-cycle start pulse. Holding start low triggers only one division.
- Core FSM: IDLE → BUSY on start pulse; BUSY runs exactly WIDTH iterations of restoring division (shift remainder left, bring in next dividend MSB, subtract divisor if remainder ≥ divisor, set quotient bit); BUSY → DONE after the last iteration; DONE → BUSY on a new start pulse.
- Start pulse while BUSY is ignored.
- DIVISOR = 0: quotient = all ones (16'hFFFF), remainder = DIVIDEND, same latency, no error flag.
- In DONE: led1..led4 = quotient[3:0]; out = hex digit of remainder[3:0] (0–F, standard hex glyphs).
- Outputs are registered and update only on entering DONE. During BUSY after a re-start, the LEDs and out keep their previous values; done is low.

## Timing
- Reset (rst=0, asynchronous): FSM IDLE, synchroniser flops = 1, done=0, led1..led4=0, out=7'b1111111 (blank). Reset mid-operation aborts the division with no residue.
- Latency: done rises on the 19th rising edge (WIDTH+3) counted from the first edge that samples start=0: 2 synchroniser stages + 1 edge/accept + WIDTH iterations.
- done falls on the edge at which a new start pulse is accepted.
- The operands are constants, so there is no operand handshake.

## Structure
- Shared package holds: WIDTH default, FSM state enum {IDLE, BUSY, DONE}, 7-segment active-low glyph constants and a hex-to-segment function.
- Sub-module division_seq_core:
  - Inputs: clk, rst, start pulse, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - Contains the FSM, iteration counter, and remainder/quotient shift registers.
- Top level contains the synchroniser, edge detector, output registers and the segment decode.

## Test plan
- Reset only, start held 1 → done=0, leds all 0, out=1111111 indefinitely.
- Defaults (1000/7): rst low 20 ns, then start low 20 ns → done high 19 clocks later. Results: quotient 142 (0x8E), so led1=0, led2=1, led3=1, led4=1. Remainder 6, so out=7'b0000010.
- DIVISOR=0, DIVIDEND=1000 → led1..led4 all 1, out = glyph '8' = 7'b0000000.
- DIVIDEND=16'hFFFF, DIVISOR=1 → leds all 1, remainder 0, out=7'b1000000.
- start held low 100 cycles, then second press after done → exactly one division per press. done drops on accept and re-rises 16 clocks later with identical results.
- rst asserted mid-BUSY (cycle 10 of iterations) → outputs return to reset values immediately. A subsequent start gives correct results.

Source files
------------

// File: rtl/division_seq_led_board_pkg.sv
// Shared types and constants for the LED-board divider demo: FSM states,
// active-low 7-segment glyphs {g,f,e,d,c,b,a} and the hex decoder.
`timescale 1ns/1ps
package division_seq_led_board_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/division_seq_core.sv
// Restoring unsigned divider, one quotient bit per clock. quotient/remainder
// carry the result of the current iteration and are final while finish is high.
`timescale 1ns/1ps
module division_seq_core
    import division_seq_led_board_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             finish,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] div_reg;
    logic             done_reg;

    logic [WIDTH-1:0] trial_lo;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_iter;

    // The shifted remainder needs WIDTH+1 bits; its top bit alone already
    // guarantees it exceeds any WIDTH-bit divisor, and the true difference
    // always fits in WIDTH bits, so the subtraction can stay WIDTH wide.
    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    always_comb begin
        trial_lo = {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
        fits     = rem_reg[WIDTH-1] | (trial_lo >= div_reg);
        rem_next = fits ? (trial_lo - div_reg) : trial_lo;
        quo_next = {quo_reg[WIDTH-2:0], fits};
    end

    assign last_iter = (state_reg == BUSY) && (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            div_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= BUSY;
                        count_reg <= '0;
                        rem_reg   <= '0;
                        quo_reg   <= dividend;
                        div_reg   <= divisor;
                        done_reg  <= 1'b0;
                    end
                end
                BUSY: begin
                    // Start pulses are ignored while iterating.
                    rem_reg   <= rem_next;
                    quo_reg   <= quo_next;
                    count_reg <= count_reg + CW'(1);
                    if (last_iter) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign quotient  = quo_next;
    assign remainder = rem_next;
    assign finish    = last_iter;
    assign done      = done_reg;

endmodule

// File: rtl/division_seq_led_board.sv
// Board top: synchronises the active-low button, starts one division per press
// and shows quotient[3:0] on LEDs and remainder[3:0] on a 7-segment digit.
`timescale 1ns/1ps
module division_seq_led_board
    import division_seq_led_board_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] DIVIDEND = WIDTH'(1000),
    parameter logic [WIDTH-1:0] DIVISOR  = WIDTH'(7)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       done,
    output logic [6:0] out,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4
);

    // Two synchroniser stages plus one delayed copy for falling-edge detection.
    logic [2:0]       sync_reg;
    logic             start_pulse;
    logic [WIDTH-1:0] core_quotient;
    logic [WIDTH-1:0] core_remainder;
    logic             core_finish;
    logic             core_done;
    logic [3:0]       led_reg;
    logic [6:0]       seg_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sync_reg[gi] <= 1'b1;
                    else      sync_reg[gi] <= start;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sync_reg[gi] <= 1'b1;
                    else      sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // A held button yields a single pulse: only the 1->0 transition counts.
    assign start_pulse = sync_reg[2] & ~sync_reg[1];

    division_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (start_pulse),
        .dividend  (DIVIDEND),
        .divisor   (DIVISOR),
        .quotient  (core_quotient),
        .remainder (core_remainder),
        .finish    (core_finish),
        .done      (core_done)
    );

    // Display registers load on the same edge the core enters DONE, so
    // they keep the previous result throughout a re-run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_reg <= 4'b0000;
            seg_reg <= SEG_BLANK;
        end else if (core_finish) begin
            led_reg <= core_quotient[3:0];
            seg_reg <= hex_to_seg(core_remainder[3:0]);
        end
    end

    assign done = core_done;
    assign out  = seg_reg;
    assign led1 = led_reg[0];
    assign led2 = led_reg[1];
    assign led3 = led_reg[2];
    assign led4 = led_reg[3];

endmodule

// File: tb/tb_division_seq_led_board.sv
// Directed bench for the LED-board divider: three builds (1000/7, 1000/0,
// FFFF/1) share clock, reset and button; each observation packs all three.
`timescale 1ns/1ps
module tb_division_seq_led_board;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b1;

    logic       done_a, done_b, done_c;
    logic [6:0] out_a, out_b, out_c;
    logic       l1_a, l2_a, l3_a, l4_a;
    logic       l1_b, l2_b, l3_b, l4_b;
    logic       l1_c, l2_c, l3_c, l4_c;

    int total = 0;
    int bad = 0;

    always #10 clk = ~clk;

    division_seq_led_board u_a (
        .clk(clk), .rst(rst), .start(start), .done(done_a), .out(out_a),
        .led1(l1_a), .led2(l2_a), .led3(l3_a), .led4(l4_a)
    );

    division_seq_led_board #(.DIVIDEND(16'd1000), .DIVISOR(16'd0)) u_b (
        .clk(clk), .rst(rst), .start(start), .done(done_b), .out(out_b),
        .led1(l1_b), .led2(l2_b), .led3(l3_b), .led4(l4_b)
    );

    division_seq_led_board #(.DIVIDEND(16'hFFFF), .DIVISOR(16'd1)) u_c (
        .clk(clk), .rst(rst), .start(start), .done(done_c), .out(out_c),
        .led1(l1_c), .led2(l2_c), .led3(l3_c), .led4(l4_c)
    );

    // Per build: {done, led4, led3, led2, led1, out[6:0]}
    logic [35:0] obs;
    assign obs = {done_a, l4_a, l3_a, l2_a, l1_a, out_a,
                  done_b, l4_b, l3_b, l2_b, l1_b, out_b,
                  done_c, l4_c, l3_c, l2_c, l1_c, out_c};

    // 1000/7 = 142 r 6 -> leds 1110, glyph 6; 1000/0 -> FFFF r 1000 (0x3E8), glyph 8;
    // FFFF/1 -> FFFF r 0, glyph 0.
    localparam logic [35:0] RST_ALL  = {12'b0_0000_1111111, 12'b0_0000_1111111, 12'b0_0000_1111111};
    localparam logic [35:0] RES_ALL  = {12'b1_1110_0000010, 12'b1_1111_0000000, 12'b1_1111_1000000};
    localparam logic [35:0] BUSY_ALL = {12'b0_1110_0000010, 12'b0_1111_0000000, 12'b0_1111_1000000};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // After press the next rising edge is edge 1 (first to sample start=0).
    task automatic press();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic release_button();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        tick(3);
        total++;
        if (obs !== RST_ALL) begin
            bad++;
            $display("FAIL reset_held: got %h want %h", obs, RST_ALL);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(40);
        total++;
        if (obs !== RST_ALL) begin
            bad++;
            $display("FAIL reset_idle: got %h want %h", obs, RST_ALL);
        end
        $display("test_reset: obs=%h", obs);
    endtask

    task automatic test_default();
        press();
        tick(1);
        release_button();
        tick(2);
        total++;
        if (obs !== RST_ALL) begin
            bad++;
            $display("FAIL default_edge3: got %h want %h", obs, RST_ALL);
        end
        tick(15);
        total++;
        if (obs !== RST_ALL) begin
            bad++;
            $display("FAIL default_edge18: got %h want %h", obs, RST_ALL);
        end
        tick(1);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL default_edge19: got %h want %h", obs, RES_ALL);
        end
        tick(5);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL default_hold: got %h want %h", obs, RES_ALL);
        end
        $display("test_default: obs=%h", obs);
    endtask

    task automatic test_hold_and_repress();
        logic dropped;
        dropped = 1'b0;
        tick(5);
        press();
        tick(2);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL hold_edge2: got %h want %h", obs, RES_ALL);
        end
        tick(1);
        total++;
        if (obs !== BUSY_ALL) begin
            bad++;
            $display("FAIL hold_accept: got %h want %h", obs, BUSY_ALL);
        end
        tick(16);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL hold_edge19: got %h want %h", obs, RES_ALL);
        end
        for (int i = 0; i < 81; i++) begin
            tick(1);
            if (done_a !== 1'b1) dropped = 1'b1;
        end
        total++;
        if (dropped !== 1'b0) begin
            bad++;
            $display("FAIL hold_single_run: got dropped=%b want 0", dropped);
        end
        $display("test_hold: 100 cycles low, obs=%h", obs);
        release_button();
        tick(6);
        press();
        tick(1);
        release_button();
        tick(1);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL repress_edge2: got %h want %h", obs, RES_ALL);
        end
        tick(1);
        total++;
        if (obs !== BUSY_ALL) begin
            bad++;
            $display("FAIL repress_accept: got %h want %h", obs, BUSY_ALL);
        end
        tick(15);
        total++;
        if (obs !== BUSY_ALL) begin
            bad++;
            $display("FAIL repress_edge18: got %h want %h", obs, BUSY_ALL);
        end
        tick(1);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL repress_edge19: got %h want %h", obs, RES_ALL);
        end
        $display("test_repress: obs=%h", obs);
    endtask

    task automatic test_busy_ignored();
        tick(5);
        press();
        tick(1);
        release_button();
        tick(4);
        press();
        tick(1);
        release_button();
        tick(12);
        total++;
        if (obs !== BUSY_ALL) begin
            bad++;
            $display("FAIL busy_ignored_edge18: got %h want %h", obs, BUSY_ALL);
        end
        tick(1);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL busy_ignored_edge19: got %h want %h", obs, RES_ALL);
        end
        tick(20);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL busy_ignored_no_rerun: got %h want %h", obs, RES_ALL);
        end
        $display("test_busy_ignored: obs=%h", obs);
    endtask

    task automatic test_reset_mid();
        tick(5);
        press();
        tick(1);
        release_button();
        tick(12);
        total++;
        if (obs !== BUSY_ALL) begin
            bad++;
            $display("FAIL mid_before_reset: got %h want %h", obs, BUSY_ALL);
        end
        #4;
        rst = 1'b0;
        #1;
        total++;
        if (obs !== RST_ALL) begin
            bad++;
            $display("FAIL mid_async_reset: got %h want %h", obs, RST_ALL);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(3);
        press();
        tick(1);
        release_button();
        tick(17);
        total++;
        if (obs !== RST_ALL) begin
            bad++;
            $display("FAIL mid_after_edge18: got %h want %h", obs, RST_ALL);
        end
        tick(1);
        total++;
        if (obs !== RES_ALL) begin
            bad++;
            $display("FAIL mid_after_edge19: got %h want %h", obs, RES_ALL);
        end
        $display("test_reset_mid: obs=%h", obs);
    endtask

    initial begin
        test_reset();
        test_default();
        test_hold_and_repress();
        test_busy_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
